// File: rtl/alu_pkg.sv
// Shared constants for the ALU command pipeline.
// Opcode encodings and result-flag bit positions.
package alu_pkg;

    localparam int ALU_DW  = 8;
    localparam int ALU_OPW = 4;

    localparam logic [3:0] ADD        = 4'd0;
    localparam logic [3:0] SUB        = 4'd1;
    localparam logic [3:0] MUL        = 4'd2;
    localparam logic [3:0] AND        = 4'd3;
    localparam logic [3:0] OR         = 4'd4;
    localparam logic [3:0] XOR        = 4'd5;
    localparam logic [3:0] XNOR       = 4'd6;
    localparam logic [3:0] NOT        = 4'd7;
    localparam logic [3:0] NAND       = 4'd8;
    localparam logic [3:0] NOR        = 4'd9;
    localparam logic [3:0] SLT        = 4'd10;
    localparam logic [3:0] SLL        = 4'd11;
    localparam logic [3:0] SLR        = 4'd12;
    localparam logic [3:0] ROL        = 4'd13;
    localparam logic [3:0] ROR        = 4'd14;
    localparam logic [3:0] OP_ILLEGAL = 4'd15;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_V = 2;
    localparam int FLG_N = 3;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO holding packed ALU commands.
// Push is ignored when full, pop is ignored when empty.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 21
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/alu_cmd_pipe.sv
// Command queue in front of the combinational ALU with a
// registered result stage, accumulator chaining and sticky overflow.
module alu_cmd_pipe
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = ALU_DW,
    parameter int OPW   = ALU_OPW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [OPW-1:0]         cmd_op,
    input  logic [DW-1:0]          cmd_a,
    input  logic [DW-1:0]          cmd_b,
    input  logic                   cmd_acc,
    output logic [DW-1:0]          alu_x,
    output logic [DW-1:0]          alu_y,
    output logic [OPW-1:0]         alu_sel,
    input  logic [DW-1:0]          alu_out,
    input  logic                   alu_zero,
    input  logic                   alu_carry,
    input  logic                   alu_overflow,
    input  logic                   alu_negative,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [DW-1:0]          res_data,
    output logic [3:0]             res_flags,
    output logic                   res_err,
    output logic                   sticky_ovf,
    input  logic                   sticky_clr,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CW = OPW + 2*DW + 1;

    logic [CW-1:0]  wdata;
    logic [CW-1:0]  rdata;
    logic           full;
    logic           empty;
    logic           push;
    logic           issue;
    logic [OPW-1:0] h_op;
    logic [DW-1:0]  h_a;
    logic [DW-1:0]  h_b;
    logic           h_acc;
    logic [DW-1:0]  acc;
    logic [3:0]     flags;

    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign wdata     = {cmd_op, cmd_a, cmd_b, cmd_acc};
    assign {h_op, h_a, h_b, h_acc} = rdata;

    assign issue = !empty && (!res_valid || res_ready);

    assign alu_sel = h_op;
    assign alu_y   = h_b;
    assign alu_x   = h_acc ? acc : h_a;

    always_comb begin
        flags        = '0;
        flags[FLG_Z] = alu_zero;
        flags[FLG_C] = alu_carry;
        flags[FLG_V] = alu_overflow;
        flags[FLG_N] = alu_negative;
    end

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wdata),
        .pop   (issue),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // acc follows every issued result, so chained commands need no stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_flags <= '0;
            res_err   <= 1'b0;
            acc       <= '0;
        end else if (issue) begin
            res_valid <= 1'b1;
            res_data  <= alu_out;
            res_flags <= flags;
            res_err   <= (h_op == OPW'(OP_ILLEGAL));
            acc       <= alu_out;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
        end else if (issue && alu_overflow) begin
            sticky_ovf <= 1'b1;
        end else if (sticky_clr) begin
            sticky_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_pipe.sv
// Randomised and directed bench for alu_cmd_pipe.
// A behavioural ALU drives the DUT; a queue model predicts results.
module tb_alu_cmd_pipe;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_acc;
    logic [7:0] alu_x;
    logic [7:0] alu_y;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_zero;
    logic       alu_carry;
    logic       alu_overflow;
    logic       alu_negative;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [3:0] res_flags;
    logic       res_err;
    logic       sticky_ovf;
    logic       sticky_clr;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    alu_cmd_pipe #(
        .DEPTH (DEPTH),
        .DW    (8),
        .OPW   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_acc      (cmd_acc),
        .alu_x        (alu_x),
        .alu_y        (alu_y),
        .alu_sel      (alu_sel),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .alu_negative (alu_negative),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_flags    (res_flags),
        .res_err      (res_err),
        .sticky_ovf   (sticky_ovf),
        .sticky_clr   (sticky_clr),
        .fifo_count   (fifo_count)
    );

    // Returns {N, V, C, Z, result}.
    function automatic logic [11:0] alu_fn(input logic [3:0] op,
                                           input logic [7:0] x,
                                           input logic [7:0] y);
        logic [8:0]  w;
        logic [15:0] p;
        logic [7:0]  r;
        logic        c;
        logic        v;
        logic [2:0]  s;
        w = '0; p = '0; r = '0; c = 1'b0; v = 1'b0;
        s = y[2:0];
        case (op)
            ADD: begin
                w = {1'b0, x} + {1'b0, y};
                r = w[7:0]; c = w[8];
                v = (x[7] == y[7]) && (r[7] != x[7]);
            end
            SUB: begin
                w = {1'b0, x} - {1'b0, y};
                r = w[7:0]; c = w[8];
                v = (x[7] != y[7]) && (r[7] != x[7]);
            end
            MUL: begin
                p = x * y;
                r = p[7:0]; c = |p[15:8];
            end
            AND:  r = x & y;
            OR:   r = x | y;
            XOR:  r = x ^ y;
            XNOR: r = ~(x ^ y);
            NOT:  r = ~x;
            NAND: r = ~(x & y);
            NOR:  r = ~(x | y);
            SLT:  r = ($signed(x) < $signed(y)) ? 8'd1 : 8'd0;
            SLL:  r = x << s;
            SLR:  r = x >> s;
            ROL: begin p = {x, x} << s; r = p[15:8]; end
            ROR: begin p = {x, x} >> s; r = p[7:0]; end
            default: r = 8'd0;
        endcase
        return {r[7], v, c, (r == 8'd0), r};
    endfunction

    always_comb begin
        {alu_negative, alu_overflow, alu_carry, alu_zero, alu_out} =
            alu_fn(alu_sel, alu_x, alu_y);
    end

    typedef struct {
        logic [7:0] d;
        logic [3:0] f;
        logic       e;
        int         lit;
    } exp_t;

    exp_t       qf[$];
    exp_t       held;
    bit         mvalid;
    bit         msticky;
    logic [7:0] macc;
    int         cur_lit = -1;
    int         nchk = 0;
    int         nfail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        qf.delete();
        mvalid  = 1'b0;
        msticky = 1'b0;
        macc    = 8'd0;
    endtask

    // One clock: check outputs, advance the model, step to next negedge.
    task automatic tick(output bit pushed);
        bit         issue;
        bit         mready;
        exp_t       e;
        logic [7:0] x;
        logic [7:0] r;
        logic [3:0] f;
        #1;
        mready = (qf.size() < DEPTH);
        chk("cmd_ready", cmd_ready, mready);
        chk("res_valid", res_valid, mvalid);
        chk("fifo_count", fifo_count, qf.size());
        chk("sticky_ovf", sticky_ovf, msticky);
        if (mvalid && res_ready) begin
            chk("res_data", res_data, held.d);
            chk("res_flags", res_flags, held.f);
            chk("res_err", res_err, held.e);
            if (held.lit >= 0) chk("res_lit", res_data, held.lit);
        end
        issue  = (qf.size() > 0) && (!mvalid || res_ready);
        pushed = cmd_valid && mready;
        if (issue) begin
            held   = qf.pop_front();
            mvalid = 1'b1;
        end else if (mvalid && res_ready) begin
            mvalid = 1'b0;
        end
        if (issue && held.f[2]) msticky = 1'b1;
        else if (sticky_clr)    msticky = 1'b0;
        if (pushed) begin
            x = cmd_acc ? macc : cmd_a;
            {f, r} = alu_fn(cmd_op, x, cmd_b);
            macc  = r;
            e.d   = r;
            e.f   = f;
            e.e   = (cmd_op == OP_ILLEGAL);
            e.lit = cur_lit;
            qf.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit p;
        for (int i = 0; i < n; i++) tick(p);
    endtask

    task automatic offer(input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic ac,
                         input int lit, input int maxc, output bit ok);
        bit p;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = ac;
        cmd_valid = 1'b1;
        cur_lit = lit;
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            tick(p);
            ok = p;
        end
        cmd_valid = 1'b0;
        cur_lit = -1;
    endtask

    task automatic send(input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic ac,
                        input int lit);
        bit ok;
        offer(op, a, b, ac, lit, 20, ok);
        chk("accept", ok, 1);
    endtask

    initial begin
        bit ok;
        bit p;
        cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; cmd_acc = 0;
        res_ready = 0; sticky_clr = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_valid", res_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_data", res_data, 0);
        chk("rst_flags", res_flags, 0);
        chk("rst_err", res_err, 0);
        chk("rst_sticky", sticky_ovf, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", cmd_ready, 1);

        res_ready = 1'b1;
        send(ADD, 8'h7F, 8'h01, 1'b0, 'h80);
        tick(p);
        chk("ovf_valid", res_valid, 1);
        chk("ovf_flags", res_flags, 4'b1100);
        chk("ovf_sticky", sticky_ovf, 1);
        idle(1);

        send(ADD, 8'h05, 8'h03, 1'b0, 'h08);
        send(ADD, 8'hEE, 8'h02, 1'b1, 'h0A);
        send(SLL, 8'hEE, 8'h01, 1'b1, 'h14);
        idle(3);

        send(OP_ILLEGAL, 8'h12, 8'h34, 1'b0, 'h00);
        tick(p);
        chk("ill_err", res_err, 1);
        chk("ill_flags", res_flags, 4'b0001);
        send(ADD, 8'h99, 8'h05, 1'b1, 'h05);
        idle(3);

        sticky_clr = 1'b1;
        tick(p);
        sticky_clr = 1'b0;
        chk("stk_pre", sticky_ovf, 0);
        send(SUB, 8'h80, 8'h01, 1'b0, 'h7F);
        sticky_clr = 1'b1;
        tick(p);
        chk("stk_setwins", sticky_ovf, 1);
        tick(p);
        sticky_clr = 1'b0;
        chk("stk_clr", sticky_ovf, 0);
        idle(2);

        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(ADD, 8'(i), 8'h01, 1'b0, i + 1);
        offer(ADD, 8'h40, 8'h01, 1'b0, -1, 3, ok);
        chk("bp_refuse", ok, 0);
        chk("bp_count", fifo_count, 4);
        chk("bp_ready", cmd_ready, 0);
        chk("bp_held", res_valid, 1);
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_drain", res_valid, 1);
            tick(p);
        end
        #1;
        chk("bp_done", res_valid, 0);
        idle(1);

        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(ADD, 8'(i), 8'(i), 1'b0, -1);
        chk("pre_rst_count", fifo_count, 3);
        chk("pre_rst_valid", res_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", res_valid, 0);
        chk("arst_count", fifo_count, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        send(ADD, 8'h55, 8'h07, 1'b1, 'h07);
        send(ADD, 8'h01, 8'h01, 1'b0, 'h02);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            cmd_valid  = ($urandom % 3) != 0;
            cmd_op     = 4'($urandom_range(0, 15));
            cmd_a      = 8'($urandom);
            cmd_b      = 8'($urandom);
            cmd_acc    = ($urandom % 2) != 0;
            res_ready  = ($urandom % 4) != 0;
            sticky_clr = ($urandom % 8) == 0;
            cur_lit    = -1;
            tick(p);
        end
        cmd_valid  = 1'b0;
        res_ready  = 1'b1;
        sticky_clr = 1'b0;
        idle(8);
        chk("end_count", fifo_count, 0);
        chk("end_valid", res_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_pipe.md
Name: alu_cmd_pipe

Overview:
Upstream command stage for the 8-bit combinational ALU. It accepts operation commands over a valid/ready handshake and buffers them in a small FIFO. It drives the ALU operand/select inputs from the FIFO head and captures the ALU result and flags into a registered output stage with its own valid/ready handshake. An internal accumulator lets chained operations take the previous result as operand x.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
DW, 8, operand/result width (must match ALU)
OPW, 4, opcode width (must match ALU select)

Ports:
clk  in  1  clock, all state rising-edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept (count < DEPTH)
cmd_op  in  OPW  ALU opcode (0..14 legal)
cmd_a  in  DW  operand x (ignored when cmd_acc=1)
cmd_b  in  DW  operand y
cmd_acc  in  1  use accumulator as x
alu_x  out  DW  to ALU x
alu_y  out  DW  to ALU y
alu_sel  out  OPW  to ALU sel
alu_out  in  DW  ALU result
alu_zero, alu_carry, alu_overflow, alu_negative  in  1 each  ALU flags
res_valid  out  1  result held
res_ready  in  1  consumer accepts result
res_data  out  DW  captured result
res_flags  out  4  {negative, overflow, carry, zero}
res_err  out  1  captured command had illegal opcode (15)
sticky_ovf  out  1  overflow seen since last clear
sticky_clr  in  1  clears sticky_ovf
fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_n=0): FIFO empty, pointers 0, fifo_count=0, res_valid=0, res_data=0, res_flags=0, res_err=0, acc=0, sticky_ovf=0. cmd_ready=1 once rst_n deasserts. Reset mid-operation discards all queued and held results; no partial issue completes.
- Push: cmd_valid && cmd_ready at an edge writes {op,a,b,acc} at the write pointer. cmd_ready depends only on count < DEPTH, with no same-cycle pop bypass: a full FIFO refuses a push even while popping.
- ALU drive (combinational from the FIFO head): alu_sel=head.op; alu_y=head.b; alu_x = head.acc ? acc : head.a. When empty, outputs hold head-slot contents; their values are don't-care.
- Issue condition: fifo not empty && (!res_valid || res_ready). On an issue edge:
  - pop the head;
  - res_data<=alu_out; res_flags<={alu_negative,alu_overflow,alu_carry,alu_zero};
  - res_err<=(head.op==15); res_valid<=1; acc<=alu_out.
- No issue and res_valid && res_ready: res_valid<=0; res_data/flags hold.
- Latency: a command pushed at edge N issues at edge N+1 at the earliest; res_valid is high after N+1. Sustained throughput is 1 result/cycle while res_ready=1.
- Accumulator chaining: acc updates at issue, so a back-to-back cmd_acc command sees the new value with no stall. acc is updated even for illegal opcodes (ALU yields 0).
- Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
- sticky_ovf: set on issue with alu_overflow=1; cleared by sticky_clr. If set and clear occur in the same cycle, set wins.
- Ordering: results leave strictly in command order; no reordering and no drop.

Decomposition:
- Package alu_pkg:
  - opcode constants ADD=0, SUB=1, MUL=2, AND=3, OR=4, XOR=5, XNOR=6, NOT=7, NAND=8, NOR=9, SLT=10, SLL=11, SLR=12, ROL=13, ROR=14, OP_ILLEGAL=15;
  - flag bit indices FLG_Z=0, FLG_C=1, FLG_V=2, FLG_N=3;
  - DW/OPW defaults.
- Sub-module alu_cmd_fifo: generic synchronous FIFO (DEPTH x packed command) exposing push/pop/full/empty/count.
- The ALU itself is instantiated by the parent, not inside this block.

Test Plan:
- ADD a=0x7F b=0x01 with res_ready=1 -> res_valid one cycle after accept; res_data=0x80, res_flags=4'b1100 (N,V), res_err=0, sticky_ovf=1.
- Chain: ADD 0x05,0x03 then cmd_acc=1 ADD b=0x02, then cmd_acc=1 SLL -> results 0x08, 0x0A, 0x14 in order on consecutive cycles.
- Backpressure: res_ready=0, offer 6 commands -> 4 accepted into the FIFO and 1 held in the output stage. cmd_ready low with fifo_count=4. Raise res_ready -> all 5 drain in order, 1 per cycle.
- Illegal op 15, a=0x12 b=0x34 -> res_data=0x00, res_flags=4'b0001, res_err=1, acc=0.
- sticky_clr asserted on the same edge as an overflowing SUB (0x80-0x01) -> sticky_ovf stays 1. sticky_clr next cycle with no overflow -> sticky_ovf=0.
- Assert rst_n=0 asynchronously with 3 queued and res_valid=1 -> immediately res_valid=0, fifo_count=0, acc=0. After release, a new ADD 0x01,0x01 yields 0x02.
